// File: rtl/hex_disp_scanner.sv
// ---------------------------------------------------------------------------
// hex_disp_scanner
//   Time-multiplexed scan controller for an N-digit common-anode 7-segment
//   display. A single external hex-to-7-seg decoder is shared by all digits.
//   The anodes rotate at a fixed slot rate. Each slot opens with a dark gap
//   so the previous digit's segments do not ghost onto the next anode. New
//   display values are staged and only committed at frame boundaries, so a
//   frame never shows a mix of old and new digits.
//
//   Load handshake: load is a single-cycle strobe with no back-pressure.
//   Every cycle with load=1 captures value_in into the pending register, and
//   a newer load overwrites an older one that is still uncommitted. At the
//   next frame boundary the pending value moves to the shadow register, and
//   load_ack pulses for exactly one cycle on the following cycle. A load in
//   the same cycle as a committing boundary stays pending for the next frame.
// ---------------------------------------------------------------------------
module hex_disp_scanner #(
    parameter int NUM_DIGITS = 4,
    parameter int CLK_DIV    = 50000,
    parameter int GAP_CYCLES = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [4*NUM_DIGITS-1:0]   value_in,
    input  logic                      load,
    output logic                      load_ack,
    input  logic                      blank_lz,
    input  logic [NUM_DIGITS-1:0]     digit_en,
    output logic [3:0]                dec_bin,
    input  logic [6:0]                dec_seg,
    output logic [6:0]                seg_out,
    output logic [NUM_DIGITS-1:0]     an_out,
    output logic                      o_dbg_state
);

    localparam int CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0] GAP_V   = CNT_W'(GAP_CYCLES);

    localparam logic [6:0] SEG_DARK = 7'h7F;

    typedef enum logic {
        ST_GAP  = 1'b0,
        ST_SHOW = 1'b1
    } state_t;

    // The slot counter restarts at zero, so the reset state is GAP unless
    // the gap has been configured away entirely.
    localparam state_t RST_STATE = (GAP_CYCLES > 0) ? ST_GAP : ST_SHOW;

    // Scan timing
    logic [CNT_W-1:0]        r_slot_cnt;
    logic [IDX_W-1:0]        r_idx;
    state_t                  r_state;

    // Display data
    logic [4*NUM_DIGITS-1:0] r_shadow;
    logic [4*NUM_DIGITS-1:0] r_pending;
    logic                    r_pend_v;
    logic                    r_load_ack;

    // Pin registers
    logic [6:0]              r_seg_out;
    logic [NUM_DIGITS-1:0]   r_an_out;

    // Combinational helpers
    logic                    w_slot_wrap;
    logic                    w_frame_end;
    logic [CNT_W-1:0]        w_next_cnt;
    logic [IDX_W-1:0]        w_next_idx;
    state_t                  w_next_state;
    logic                    w_commit;
    logic [3:0]              w_dec_bin;
    logic                    w_dig_en;
    logic                    w_blank;
    logic [NUM_DIGITS-1:0]   w_an_sel;
    logic [NUM_DIGITS-1:0]   w_upper_zero;
    logic                    w_zero_acc;

    // Slot counter wrap, frame boundary and next-cycle timing values
    always_comb begin
        w_slot_wrap  = (r_slot_cnt == CNT_MAX);
        w_frame_end  = w_slot_wrap && (r_idx == IDX_MAX);
        w_next_cnt   = w_slot_wrap ? '0 : r_slot_cnt + 1'b1;
        if (w_slot_wrap) begin
            w_next_idx = (r_idx == IDX_MAX) ? '0 : r_idx + 1'b1;
        end else begin
            w_next_idx = r_idx;
        end
        w_next_state = (w_next_cnt < GAP_V) ? ST_GAP : ST_SHOW;
        w_commit     = w_frame_end && r_pend_v;
    end

    // Per-digit selection: decoder nibble, enable, anode pattern and the
    // leading-zero run (digit k is in the run when nibbles k..top are zero)
    always_comb begin
        w_dec_bin    = 4'h0;
        w_dig_en     = 1'b0;
        w_an_sel     = '1;
        w_upper_zero = '1;
        w_zero_acc   = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            w_zero_acc      = w_zero_acc && (r_shadow[4*k +: 4] == 4'h0);
            w_upper_zero[k] = w_zero_acc;
        end
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (r_idx == IDX_W'(k)) begin
                w_dec_bin   = r_shadow[4*k +: 4];
                w_dig_en    = digit_en[k];
                w_an_sel[k] = 1'b0;
            end
        end
        // Digit 0 always shows, so a zero value still displays "0".
        w_blank = blank_lz && (r_idx != '0) && w_upper_zero[r_idx];
    end

    // Scan FSM: slot counter, digit index and GAP/SHOW state, all driven by
    // the slot counter alone
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_slot_cnt <= '0;
            r_idx      <= '0;
            r_state    <= RST_STATE;
        end else begin
            r_slot_cnt <= w_next_cnt;
            r_idx      <= w_next_idx;
            r_state    <= w_next_state;
        end
    end

    // Load staging and frame-boundary commit; a same-cycle load lands in
    // pending after the old pending value has moved to the shadow
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shadow   <= '0;
            r_pending  <= '0;
            r_pend_v   <= 1'b0;
            r_load_ack <= 1'b0;
        end else begin
            r_load_ack <= w_commit;
            if (w_commit) begin
                r_shadow <= r_pending;
                r_pend_v <= 1'b0;
            end
            if (load) begin
                r_pending <= value_in;
                r_pend_v  <= 1'b1;
            end
        end
    end

    // Pin registers: anodes and segments update together from the current
    // state, so they change on the same edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_seg_out <= SEG_DARK;
            r_an_out  <= '1;
        end else if (r_state == ST_GAP || !w_dig_en) begin
            r_seg_out <= SEG_DARK;
            r_an_out  <= '1;
        end else if (w_blank) begin
            r_seg_out <= SEG_DARK;
            r_an_out  <= w_an_sel;
        end else begin
            r_seg_out <= dec_seg;
            r_an_out  <= w_an_sel;
        end
    end

    assign dec_bin     = w_dec_bin;
    assign seg_out     = r_seg_out;
    assign an_out      = r_an_out;
    assign load_ack    = r_load_ack;
    assign o_dbg_state = r_state;

endmodule
